// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game datapath and the game-flow sequencer.
// The datapath side is the master; the sequencer is the slave.
interface game_flow_ctrl_if #(
  parameter int NUM_LEVELS = 4
);
  localparam int LW = $clog2(NUM_LEVELS);

  logic          game_over;
  logic          cmd_done;
  logic          diff;
  logic          mode_pb;
  logic          pause_pb;
  logic          init_cycle;
  logic          enable_loop;
  logic          en_update;
  logic          paused;
  logic          sync_reset;
  logic [LW-1:0] level;
  logic          timeout_err;
  logic [2:0]    state_o;

  modport master (
    output game_over, cmd_done, diff, mode_pb, pause_pb,
    input  init_cycle, enable_loop, en_update, paused, sync_reset,
           level, timeout_err, state_o
  );

  modport slave (
    input  game_over, cmd_done, diff, mode_pb, pause_pb,
    output init_cycle, enable_loop, en_update, paused, sync_reset,
           level, timeout_err, state_o
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: display init, main loop, difficulty update, pause and
// game-over/restart, with a cmd_done watchdog and a restart hold-off in OVER.
module game_flow_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_TIMEOUT = 1000000,
  parameter int NUM_LEVELS  = 4,
  parameter int OVER_HOLD   = 50000
) (
  input logic            clk,
  input logic            nrst,
  game_flow_ctrl_if.slave bus
);
  localparam int LW  = $clog2(NUM_LEVELS);
  localparam int WDW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
  localparam int HW  = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

  localparam logic [WDW-1:0] WDOG_LAST = WDW'((CMD_TIMEOUT > 0) ? CMD_TIMEOUT - 1 : 0);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(OVER_HOLD);
  localparam logic [LW-1:0]  LEVEL_MAX = LW'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_LOOP   = 3'd1,
    S_UPDATE = 3'd2,
    S_PAUSE  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] mode_sync, pause_sync;
  logic                   mode_dly, pause_dly;
  logic                   mode_edge, pause_edge;

  logic [WDW-1:0] wdog;
  logic [HW-1:0]  hold;
  logic [LW-1:0]  level;
  logic           timeout_err;

  logic wdog_expire, hold_done;
  logic level_inc, level_clr, err_set, err_clr, wdog_restart;

  // Raw buttons are asynchronous: a flop chain settles them, the extra delay
  // flop turns a held press into a single rising-edge pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_sync  <= '0;
      pause_sync <= '0;
      mode_dly   <= 1'b0;
      pause_dly  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value and the chain shifts by exactly one stage.
      mode_sync  <= {mode_sync[SYNC_STAGES-2:0], bus.mode_pb};
      pause_sync <= {pause_sync[SYNC_STAGES-2:0], bus.pause_pb};
      mode_dly   <= mode_sync[SYNC_STAGES-1];
      pause_dly  <= pause_sync[SYNC_STAGES-1];
    end
  end

  assign mode_edge  = mode_sync[SYNC_STAGES-1] & ~mode_dly;
  assign pause_edge = pause_sync[SYNC_STAGES-1] & ~pause_dly;

  // cmd_done arriving in the last watchdog cycle still counts as on time.
  assign wdog_expire = (CMD_TIMEOUT != 0) && (wdog == WDOG_LAST) && !bus.cmd_done;
  assign hold_done   = (hold == HOLD_MAX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt    = state;
    level_inc    = 1'b0;
    level_clr    = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    wdog_restart = 1'b0;
    case (state)
      S_INIT: begin
        if (bus.cmd_done) begin
          state_nxt = S_LOOP;
        end else if (wdog_expire) begin
          err_set      = 1'b1;
          wdog_restart = 1'b1;
        end
      end
      S_LOOP: begin
        if (bus.game_over) begin
          state_nxt = S_OVER;
        end else if (bus.diff) begin
          state_nxt = S_UPDATE;
          level_inc = 1'b1;
        end else if (pause_edge) begin
          state_nxt = S_PAUSE;
        end
      end
      S_UPDATE: begin
        if (bus.game_over) begin
          state_nxt = S_OVER;
        end else if (bus.cmd_done) begin
          state_nxt = S_LOOP;
        end else if (wdog_expire) begin
          state_nxt = S_INIT;
          err_set   = 1'b1;
        end
      end
      S_PAUSE: begin
        if (bus.game_over) begin
          state_nxt = S_OVER;
        end else if (pause_edge) begin
          state_nxt = S_LOOP;
        end
      end
      S_OVER: begin
        // Early presses are simply dropped; only an edge after the hold-off restarts.
        if (mode_edge && hold_done) begin
          state_nxt = S_INIT;
          level_clr = 1'b1;
          err_clr   = 1'b1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_INIT;
      level       <= '0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      hold        <= '0;
    end else begin
      state <= state_nxt;

      if (level_clr) begin
        level <= '0;
      end else if (level_inc && (level != LEVEL_MAX)) begin
        level <= level + 1'b1;
      end

      if (err_clr) begin
        timeout_err <= 1'b0;
      end else if (err_set) begin
        timeout_err <= 1'b1;
      end

      if ((state_nxt != state) || wdog_restart) begin
        wdog <= '0;
      end else if ((CMD_TIMEOUT != 0) && ((state == S_INIT) || (state == S_UPDATE))) begin
        wdog <= wdog + 1'b1;
      end

      if ((state != S_OVER) || (state_nxt != S_OVER)) begin
        hold <= '0;
      end else if (!hold_done) begin
        hold <= hold + 1'b1;
      end
    end
  end

  assign bus.init_cycle  = (state == S_INIT);
  assign bus.enable_loop = (state == S_LOOP);
  assign bus.en_update   = (state == S_UPDATE);
  assign bus.paused      = (state == S_PAUSE);
  assign bus.sync_reset  = (state == S_OVER);
  assign bus.state_o     = state;
  assign bus.level       = level;
  assign bus.timeout_err = timeout_err;
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game-flow sequencer for the snake-style game datapath. It handles the power-on display init handshake, the main game loop, difficulty updates, a user pause, and game-over/restart. It generalises the earlier 4-state controller with these additions:
- parametrised button synchronisers
- a cmd_done watchdog with retry
- a saturating difficulty-level counter
- a PAUSE state
- a minimum hold time in OVER before restart is accepted
All outputs are Moore (decoded from registered state only).

Parameters:
SYNC_STAGES, 2, flip-flop depth of each push-button synchroniser (legal range 2..4).
CMD_TIMEOUT, 1000000, cycles to wait for cmd_done in INIT/UPDATE before timeout; 0 disables the watchdog.
NUM_LEVELS, 4, number of difficulty levels (legal range 2..16).
OVER_HOLD, 50000, cycles spent in OVER before a mode_pb edge is honoured.

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
game_over  in  1  level: game ended, from collision logic
cmd_done  in  1  1-cycle pulse: display command sequence finished
diff  in  1  1-cycle pulse: difficulty-up request
mode_pb  in  1  raw restart push-button, async
pause_pb  in  1  raw pause push-button, async
init_cycle  out  1  high in INIT
enable_loop  out  1  high in LOOP
en_update  out  1  high in UPDATE
paused  out  1  high in PAUSE
sync_reset  out  1  high in OVER
level  out  $clog2(NUM_LEVELS)  current difficulty level
timeout_err  out  1  sticky watchdog flag
state_o  out  3  INIT=0, LOOP=1, UPDATE=2, PAUSE=3, OVER=4

Behaviour:
- Reset (nrst low):
  - state=INIT, level=0, timeout_err=0, wdog counter=0, hold counter=0, all sync/edge flops=0.
  - Resulting outputs: init_cycle=1, all other flag outputs 0.
  - Reset mid-operation aborts any state immediately.
- Button path:
  - SYNC_STAGES flop chain per button, then a delay flop.
  - Edge pulse = synced & ~delayed.
  - A button first sampled high at edge k produces its pulse after edge k+SYNC_STAGES-1; the state reacts at edge k+SYNC_STAGES.
  - A button held high generates exactly one pulse.
- Transitions (evaluated every cycle; priority listed top-down):
  - INIT:
    - cmd_done -> LOOP.
    - Otherwise, watchdog expiry -> stay INIT, wdog counter restarts, timeout_err<=1.
  - LOOP:
    - game_over -> OVER.
    - Otherwise diff -> UPDATE, and level<=min(level+1, NUM_LEVELS-1).
    - Otherwise pause edge -> PAUSE.
    - Otherwise stay LOOP.
  - UPDATE:
    - game_over -> OVER.
    - Otherwise cmd_done -> LOOP.
    - Otherwise watchdog expiry -> INIT, timeout_err<=1.
  - PAUSE:
    - game_over -> OVER.
    - Otherwise pause edge -> LOOP.
    - diff pulses are ignored, with no level change.
  - OVER:
    - The hold counter counts from 0 while in OVER and saturates at OVER_HOLD.
    - A mode_pb edge while counter==OVER_HOLD -> INIT; level<=0, timeout_err<=0.
    - Edges while counter<OVER_HOLD are discarded, not queued.
- Watchdog:
  - The counter clears on every state change and is 0 on entry.
  - It increments each cycle spent in INIT or UPDATE.
  - Expiry = counter==CMD_TIMEOUT-1 with no cmd_done that cycle.
  - cmd_done in the expiry cycle wins.
  - With CMD_TIMEOUT=0 the watchdog never expires.
- Hold counter: clears on leaving OVER.
- Level arithmetic: saturating, never wraps; width $clog2(NUM_LEVELS).
- Simultaneous events: game_over beats diff/pause/cmd_done in every state except INIT, where game_over is ignored.
- Latency: every state output changes on the clock edge after the triggering input cycle.

Test Plan:
1. Reset, hold cmd_done=0 for 10 cycles (CMD_TIMEOUT=8) -> init_cycle=1 throughout, timeout_err=1 after cycle 8; cmd_done pulse -> state_o=1, enable_loop=1 next cycle.
2. In LOOP, 5 diff pulses each followed by cmd_done (NUM_LEVELS=4) -> level sequence 1,2,3,3,3; en_update high exactly one cycle per pulse (cmd_done the next cycle).
3. In LOOP, assert diff and game_over in the same cycle -> state_o=4, level unchanged, sync_reset=1.
4. pause_pb high for 20 cycles (SYNC_STAGES=2) -> PAUSE entered at edge k+2 and held; diff pulses in PAUSE leave level unchanged; second press -> LOOP.
5. In OVER (OVER_HOLD=16), press mode_pb at cycle 5 -> stays OVER; press again at cycle 20 -> INIT, level=0, timeout_err=0.
6. In UPDATE with no cmd_done (CMD_TIMEOUT=8) -> INIT after 8 cycles, timeout_err=1; assert nrst low mid-UPDATE -> immediate INIT, level=0.
